write_merge_buffer: RTL and testbench
=====================================

Name: write_merge_buffer

Overview:
- Single-line write-combining buffer between the CPU write path and the SDRAM controller, alongside the two-way read cache.
- Absorbs CPU word/byte writes into one 8-word (16-byte) line with per-byte valid flags and acks the CPU immediately.
- Flushes the line to SDRAM as one 8-word write burst with per-word DQM masks.
- Upstream coherence logic uses flush_req/empty to drain the buffer before a read is allowed to reach SDRAM.

Parameters:
IDLE_FLUSH, 64, cycles after the last merged write before an automatic flush (2..255)

Ports:
clk  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
cpu_addr  input  32  CPU byte address; [31:4] line, [3:1] word within line
cpu_req  input  1  write request, level; held until cpu_ack, then dropped
cpu_ack  output  1  one-cycle pulse: write absorbed
cpu_rwl  input  1  active-low lower-byte write enable
cpu_rwu  input  1  active-low upper-byte write enable
data_from_cpu  input  16  write data
flush_req  input  1  level; forces flush of a held line
empty  output  1  1 = no valid bytes held and no flush in progress
sdram_addr  output  32  burst base address {line,4'b0000}
sdram_req  output  1  burst request, held for the whole burst
sdram_rw  output  1  0 during a write burst, 1 otherwise
data_to_sdram  output  16  current burst word
sdram_dqm  output  2  current word masks {upper,lower}; 1 = byte not written
sdram_wrnext  input  1  controller consumed current word; exactly 8 pulses per burst, gaps allowed

Behaviour:
- Storage: 8x16 data registers; 16 byte-valid bits; 28-bit line tag; 3-bit burst word index; idle counter sized for IDLE_FLUSH.
- Reset (asynchronous, active-low):
  - State = IDLE; valid bits cleared; buffered data discarded, including mid-burst.
  - Outputs: cpu_ack=0, sdram_req=0, sdram_rw=1, sdram_addr=0, data_to_sdram=0, sdram_dqm=2'b11, empty=1.
- IDLE, cpu_req=1:
  - Capture tag=cpu_addr[31:4].
  - Write data_from_cpu into word cpu_addr[3:1]; set the valid bit of each byte whose enable is 0.
  - Pulse cpu_ack next cycle; go to WAITREL.
  - If both byte enables are 1: ack only, valid bits unchanged, return to IDLE after release.
- IDLE, flush_req=1: no action; empty stays 1.
- HOLD (line valid) priority, highest first:
  1. flush_req=1 -> FLUSH. A same-cycle write is not merged and stalls.
  2. cpu_req=1, same line -> merge (newer bytes overwrite), ack next cycle, clear idle counter, go to WAITREL.
  3. cpu_req=1, different line -> FLUSH with no ack. The write is accepted from IDLE after the burst completes.
  4. Idle counter reaches IDLE_FLUSH-1 -> FLUSH.
  5. Otherwise increment the idle counter.
- WAITREL: wait for cpu_req=0, then go to HOLD if any valid bit is set, else IDLE. The idle counter runs in this state.
- FLUSH:
  - sdram_req=1, sdram_rw=0, sdram_addr={tag,4'b0000}; word index starts at 0.
  - data_to_sdram = word[index]; sdram_dqm = ~{valid_u[index],valid_l[index]}.
  - Each sdram_wrnext advances the index; the next word is presented the following cycle.
  - On the 8th wrnext: next edge clears all valid bits, sdram_req=0, sdram_rw=1, state=IDLE, empty=1.
  - Fully masked words (dqm=2'b11) are still sent; burst length is always 8.
  - cpu_req during FLUSH is stalled, never merged.
- sdram_wrnext outside FLUSH is ignored.
- empty = 1 only in IDLE with no valid bits. It is 0 from the edge that absorbs the first byte until the edge that ends the burst.
- Latency:
  - Absorbed write: ack 1 cycle after cpu_req seen.
  - Conflicting write: ack delayed by the burst plus 2 cycles.

Test Plan:
- Single write 0x0000_1236 data 0xBEEF, rwl=rwu=0 -> ack pulse 1 cycle later, empty=0; after 64 idle cycles a burst at 0x0000_1230: word 3 = 0xBEEF dqm 00, other 7 words dqm 11.
- Writes to 0x100 (0x1111, both bytes), 0x102 (upper only 0xAB00), 0x100 (lower only 0x0022), then flush_req -> burst at 0x100: w0=0x1122 dqm 00, w1 upper=0xAB dqm 01, w2..w7 dqm 11; empty=1 the cycle after the 8th wrnext.
- Line 0x200 held, write to 0x300 -> no ack; 8-word burst for 0x200 with wrnext gaps of 0-3 cycles; then the 0x300 write is acked and held.
- flush_req and a same-line cpu_req in the same HOLD cycle -> flush wins, no merge; write acked after the burst into a fresh line.
- Reset low after the 4th wrnext -> sdram_req=0, empty=1, dqm=11 immediately; no further burst after release.
- Write with rwl=rwu=1 from IDLE -> ack, empty stays 1, no burst ever issued.

Source files
------------

// File: rtl/write_merge_buffer.sv
// Single-line write-combining buffer: merges CPU byte/word writes into one
// 16-byte line and drains it to SDRAM as a fixed 8-word masked write burst.
module write_merge_buffer #(
    parameter int IDLE_FLUSH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_req,
    output logic        cpu_ack,
    input  logic        cpu_rwl,
    input  logic        cpu_rwu,
    input  logic [15:0] data_from_cpu,
    input  logic        flush_req,
    output logic        empty,
    output logic [31:0] sdram_addr,
    output logic        sdram_req,
    output logic        sdram_rw,
    output logic [15:0] data_to_sdram,
    output logic [1:0]  sdram_dqm,
    input  logic        sdram_wrnext
);

    localparam logic [7:0] IDLE_LAST = 8'(IDLE_FLUSH - 1);

    typedef enum logic [1:0] {IDLE, WAITREL, HOLD, FLUSH} state_t;

    state_t      state, state_next;
    logic [15:0] words [8];
    logic [7:0]  valid_l, valid_u;
    logic [27:0] tag;
    logic [2:0]  word_idx;
    logic [7:0]  idle_cnt;

    logic        absorb, start_line, cnt_clr, cnt_inc, burst_done;
    logic        same_line, any_valid;
    logic [2:0]  cpu_word;
    logic        addr_lsb_unused;

    assign cpu_word        = cpu_addr[3:1];
    assign same_line       = (cpu_addr[31:4] == tag);
    assign any_valid       = |{valid_l, valid_u};
    assign addr_lsb_unused = cpu_addr[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A write to a different line while holding forces a flush without ack;
    // the CPU keeps requesting and is picked up from IDLE after the burst.
    always_comb begin
        state_next = state;
        absorb     = 1'b0;
        start_line = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        burst_done = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (cpu_req) begin
                    absorb     = 1'b1;
                    start_line = 1'b1;
                    state_next = WAITREL;
                end
            end
            WAITREL: begin
                if (idle_cnt < IDLE_LAST) cnt_inc = 1'b1;
                if (!cpu_req) state_next = any_valid ? HOLD : IDLE;
            end
            HOLD: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (cpu_req && same_line) begin
                    absorb     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = WAITREL;
                end else if (cpu_req) begin
                    state_next = FLUSH;
                end else if (idle_cnt >= IDLE_LAST) begin
                    state_next = FLUSH;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FLUSH: begin
                if (sdram_wrnext && (word_idx == 3'd7)) begin
                    burst_done = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Only enabled bytes are written so a partial merge never clobbers older bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_ack  <= 1'b0;
            tag      <= '0;
            valid_l  <= '0;
            valid_u  <= '0;
            idle_cnt <= '0;
            word_idx <= '0;
            for (int i = 0; i < 8; i++) words[i] <= '0;
        end else begin
            cpu_ack <= absorb;
            if (start_line) tag <= cpu_addr[31:4];
            if (absorb && !cpu_rwl) begin
                words[cpu_word][7:0] <= data_from_cpu[7:0];
                valid_l[cpu_word]    <= 1'b1;
            end
            if (absorb && !cpu_rwu) begin
                words[cpu_word][15:8] <= data_from_cpu[15:8];
                valid_u[cpu_word]     <= 1'b1;
            end
            if (burst_done) begin
                valid_l <= '0;
                valid_u <= '0;
            end
            if (cnt_clr)      idle_cnt <= '0;
            else if (cnt_inc) idle_cnt <= idle_cnt + 8'd1;
            if (state != FLUSH)    word_idx <= '0;
            else if (sdram_wrnext) word_idx <= word_idx + 3'd1;
        end
    end

    assign empty         = !any_valid && (state != FLUSH);
    assign sdram_req     = (state == FLUSH);
    assign sdram_rw      = (state != FLUSH);
    assign sdram_addr    = (state == FLUSH) ? {tag, 4'b0000} : 32'h0;
    assign data_to_sdram = (state == FLUSH) ? words[word_idx] : 16'h0;
    assign sdram_dqm     = (state == FLUSH) ? ~{valid_u[word_idx], valid_l[word_idx]} : 2'b11;

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed bench for write_merge_buffer: merge, idle/forced/conflict flushes,
// mid-burst reset and no-byte writes, checked with immediate assertions.
module tb_write_merge_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_req;
    logic        cpu_ack;
    logic        cpu_rwl, cpu_rwu;
    logic [15:0] data_from_cpu;
    logic        flush_req;
    logic        empty;
    logic [31:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_rw;
    logic [15:0] data_to_sdram;
    logic [1:0]  sdram_dqm;
    logic        sdram_wrnext;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] bAddr;
    logic        bRw;
    logic [15:0] bData [8];
    logic [15:0] dqmAll;
    logic        bEmptyAfter, bReqAfter, ackDuringBurst, ackEmpty;
    int          gapTable [8] = '{0, 3, 1, 2, 0, 3, 2, 0};
    int          lat, cnt;

    write_merge_buffer #(.IDLE_FLUSH(64)) dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_req(cpu_req),
        .cpu_ack(cpu_ack), .cpu_rwl(cpu_rwl), .cpu_rwu(cpu_rwu),
        .data_from_cpu(data_from_cpu), .flush_req(flush_req), .empty(empty),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_rw(sdram_rw),
        .data_to_sdram(data_to_sdram), .sdram_dqm(sdram_dqm),
        .sdram_wrnext(sdram_wrnext)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic startWrite(input logic [31:0] addr, input logic [15:0] data,
                              input logic rwl, input logic rwu);
        cpu_addr      = addr;
        data_from_cpu = data;
        cpu_rwl       = rwl;
        cpu_rwu       = rwu;
        cpu_req       = 1'b1;
    endtask

    // Returns cycles until ack (-1 on timeout), then releases the request.
    task automatic waitAck(output int latency);
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!cpu_ack && latency < 300);
        if (!cpu_ack) latency = -1;
        ackEmpty = empty;
        cpu_req  = 1'b0;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] data,
                                 input logic rwl, input logic rwu, output int latency);
        startWrite(addr, data, rwl, rwu);
        waitAck(latency);
    endtask

    // Acts as the SDRAM controller for one burst, optionally with wrnext gaps.
    task automatic captureBurst(input bit useGaps);
        int waited = 0;
        while (!sdram_req && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("burst_start", {31'd0, sdram_req}, 32'd1);
        if (!sdram_req) return;
        flush_req      = 1'b0;
        ackDuringBurst = 1'b0;
        bAddr          = sdram_addr;
        bRw            = sdram_rw;
        for (int i = 0; i < 8; i++) begin
            bData[i]          = data_to_sdram;
            dqmAll[2*i +: 2]  = sdram_dqm;
            if (cpu_ack) ackDuringBurst = 1'b1;
            sdram_wrnext = 1'b1;
            @(negedge clk);
            sdram_wrnext = 1'b0;
            if (cpu_ack) ackDuringBurst = 1'b1;
            if (useGaps && i < 7) begin
                for (int g = 0; g < gapTable[i]; g++) begin
                    @(negedge clk);
                    if (cpu_ack) ackDuringBurst = 1'b1;
                end
            end
        end
        bEmptyAfter = empty;
        bReqAfter   = sdram_req;
    endtask

    initial begin
        reset = 1'b0; cpu_addr = '0; cpu_req = 1'b0; cpu_rwl = 1'b1; cpu_rwu = 1'b1;
        data_from_cpu = '0; flush_req = 1'b0; sdram_wrnext = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ack",   {31'd0, cpu_ack},   32'd0);
        checkOutput("rst_req",   {31'd0, sdram_req}, 32'd0);
        checkOutput("rst_rw",    {31'd0, sdram_rw},  32'd1);
        checkOutput("rst_addr",  sdram_addr,         32'd0);
        checkOutput("rst_data",  {16'd0, data_to_sdram}, 32'd0);
        checkOutput("rst_dqm",   {30'd0, sdram_dqm}, 32'd3);
        checkOutput("rst_empty", {31'd0, empty},     32'd1);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] single write, idle flush");
        applyStimulus(32'h0000_1236, 16'hBEEF, 1'b0, 1'b0, lat);
        checkOutput("t1_ack_lat", 32'(lat), 32'd1);
        checkOutput("t1_empty",   {31'd0, empty}, 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (sdram_req) cnt++;
        end
        checkOutput("t1_no_early_burst", 32'(cnt), 32'd0);
        captureBurst(1'b0);
        checkOutput("t1_addr",  bAddr, 32'h0000_1230);
        checkOutput("t1_rw",    {31'd0, bRw}, 32'd0);
        checkOutput("t1_w3",    {16'd0, bData[3]}, 32'h0000_BEEF);
        checkOutput("t1_dqm",   {16'd0, dqmAll}, 32'h0000_FF3F);
        checkOutput("t1_empty_after", {31'd0, bEmptyAfter}, 32'd1);
        checkOutput("t1_req_after",   {31'd0, bReqAfter},   32'd0);

        $display("[TB] merged writes, forced flush");
        applyStimulus(32'h0000_0100, 16'h1111, 1'b0, 1'b0, lat);
        checkOutput("t2_lat0", 32'(lat), 32'd1);
        applyStimulus(32'h0000_0102, 16'hAB00, 1'b1, 1'b0, lat);
        checkOutput("t2_lat1", 32'(lat), 32'd1);
        applyStimulus(32'h0000_0100, 16'h0022, 1'b0, 1'b1, lat);
        checkOutput("t2_lat2", 32'(lat), 32'd1);
        flush_req = 1'b1;
        captureBurst(1'b0);
        checkOutput("t2_addr", bAddr, 32'h0000_0100);
        checkOutput("t2_w0",   {16'd0, bData[0]}, 32'h0000_1122);
        checkOutput("t2_w1u",  {24'd0, bData[1][15:8]}, 32'h0000_00AB);
        checkOutput("t2_dqm",  {16'd0, dqmAll}, 32'h0000_FFF4);
        checkOutput("t2_empty_after", {31'd0, bEmptyAfter}, 32'd1);

        $display("[TB] conflicting line write with wrnext gaps");
        applyStimulus(32'h0000_0200, 16'h2222, 1'b0, 1'b0, lat);
        checkOutput("t3_lat0", 32'(lat), 32'd1);
        startWrite(32'h0000_0300, 16'h3333, 1'b0, 1'b0);
        captureBurst(1'b1);
        checkOutput("t3_addr",   bAddr, 32'h0000_0200);
        checkOutput("t3_w0",     {16'd0, bData[0]}, 32'h0000_2222);
        checkOutput("t3_dqm",    {16'd0, dqmAll}, 32'h0000_FFFC);
        checkOutput("t3_no_ack", {31'd0, ackDuringBurst}, 32'd0);
        checkOutput("t3_empty_after", {31'd0, bEmptyAfter}, 32'd1);
        waitAck(lat);
        checkOutput("t3_ack_after_burst", 32'(lat), 32'd1);
        checkOutput("t3_held", {31'd0, empty}, 32'd0);
        flush_req = 1'b1;
        captureBurst(1'b0);
        checkOutput("t3_addr2", bAddr, 32'h0000_0300);
        checkOutput("t3_w0b",   {16'd0, bData[0]}, 32'h0000_3333);

        $display("[TB] flush beats same-cycle merge");
        applyStimulus(32'h0000_0400, 16'h4444, 1'b0, 1'b0, lat);
        checkOutput("t4_lat0", 32'(lat), 32'd1);
        flush_req = 1'b1;
        startWrite(32'h0000_0402, 16'h5555, 1'b0, 1'b0);
        captureBurst(1'b0);
        checkOutput("t4_addr",   bAddr, 32'h0000_0400);
        checkOutput("t4_dqm",    {16'd0, dqmAll}, 32'h0000_FFFC);
        checkOutput("t4_no_ack", {31'd0, ackDuringBurst}, 32'd0);
        waitAck(lat);
        checkOutput("t4_ack_after_burst", 32'(lat), 32'd1);
        flush_req = 1'b1;
        captureBurst(1'b0);
        checkOutput("t4_addr2", bAddr, 32'h0000_0400);
        checkOutput("t4_w1",    {16'd0, bData[1]}, 32'h0000_5555);
        checkOutput("t4_dqm2",  {16'd0, dqmAll}, 32'h0000_FFF3);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(32'h0000_0500, 16'h6666, 1'b0, 1'b0, lat);
        flush_req = 1'b1;
        cnt = 0;
        while (!sdram_req && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("t5_burst_start", {31'd0, sdram_req}, 32'd1);
        flush_req = 1'b0;
        repeat (4) begin
            sdram_wrnext = 1'b1;
            @(negedge clk);
            sdram_wrnext = 1'b0;
        end
        reset = 1'b0;
        #1;
        checkOutput("t5_req",   {31'd0, sdram_req}, 32'd0);
        checkOutput("t5_empty", {31'd0, empty},     32'd1);
        checkOutput("t5_dqm",   {30'd0, sdram_dqm}, 32'd3);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (sdram_req) cnt++;
        end
        checkOutput("t5_no_burst", 32'(cnt), 32'd0);

        $display("[TB] write with no byte enables");
        applyStimulus(32'h0000_0600, 16'h7777, 1'b1, 1'b1, lat);
        checkOutput("t6_lat",       32'(lat), 32'd1);
        checkOutput("t6_empty_ack", {31'd0, ackEmpty}, 32'd1);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (sdram_req || !empty) cnt++;
        end
        checkOutput("t6_no_burst", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
